// File: rtl/cdb_arbiter_if.sv
// Result-producer and CDB broadcast signals of the CDB arbiter.
// The producers/observer side uses master; the arbiter uses slave.
interface cdb_arbiter_if #(
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32
);
    logic                alu_valid;
    logic [ROB_ID_W-1:0] alu_alias;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_jump_res;
    logic [DATA_W-1:0]   alu_jump_pc;
    logic                alu_ready;

    logic                lsb_valid;
    logic [ROB_ID_W-1:0] lsb_alias;
    logic [DATA_W-1:0]   lsb_result;
    logic                lsb_ready;

    logic                cdb_valid;
    logic                cdb_src;
    logic [ROB_ID_W-1:0] cdb_alias;
    logic [DATA_W-1:0]   cdb_result;
    logic                cdb_jump_res;
    logic [DATA_W-1:0]   cdb_jump_pc;

    modport master (
        output alu_valid, alu_alias, alu_result, alu_jump_res, alu_jump_pc,
        input  alu_ready,
        output lsb_valid, lsb_alias, lsb_result,
        input  lsb_ready,
        input  cdb_valid, cdb_src, cdb_alias, cdb_result, cdb_jump_res, cdb_jump_pc
    );

    modport slave (
        input  alu_valid, alu_alias, alu_result, alu_jump_res, alu_jump_pc,
        output alu_ready,
        input  lsb_valid, lsb_alias, lsb_result,
        output lsb_ready,
        output cdb_valid, cdb_src, cdb_alias, cdb_result, cdb_jump_res, cdb_jump_pc
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Shares the common data bus between the ALU and LSB: one small FIFO per producer,
// round-robin drain of one entry per cycle onto a registered broadcast, flushed on rollback.
module cdb_arbiter #(
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32,
    parameter int QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rollback_signal,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   result;
        logic                jump_res;
        logic [DATA_W-1:0]   jump_pc;
    } alu_ent_t;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   result;
    } lsb_ent_t;

    alu_ent_t            alu_mem [QDEPTH];
    lsb_ent_t            lsb_mem [QDEPTH];
    logic [PTR_W-1:0]    alu_wr_ptr, alu_rd_ptr, lsb_wr_ptr, lsb_rd_ptr;
    logic [CNT_W-1:0]    alu_cnt, lsb_cnt;

    src_e                rr_last, rr_next;
    logic                sched_en, alu_ne, lsb_ne;
    logic                alu_enq, lsb_enq, pop_alu, pop_lsb;
    alu_ent_t            alu_head;
    lsb_ent_t            lsb_head;

    logic                cdb_valid_q;
    src_e                cdb_src_q;
    logic [ROB_ID_W-1:0] cdb_alias_q;
    logic [DATA_W-1:0]   cdb_result_q;
    logic                cdb_jump_res_q;
    logic [DATA_W-1:0]   cdb_jump_pc_q;

    assign sched_en = rdy & ~rollback_signal;
    assign alu_ne   = (alu_cnt != '0);
    assign lsb_ne   = (lsb_cnt != '0);

    assign bus.alu_ready = sched_en & (alu_cnt != FULL);
    assign bus.lsb_ready = sched_en & (lsb_cnt != FULL);
    assign alu_enq       = bus.alu_valid & bus.alu_ready;
    assign lsb_enq       = bus.lsb_valid & bus.lsb_ready;

    // On a tie the source that did not win last time goes first.
    assign pop_alu = sched_en & alu_ne & (~lsb_ne | (rr_last == SRC_LSB));
    assign pop_lsb = sched_en & lsb_ne & ~pop_alu;

    assign alu_head = alu_mem[alu_rd_ptr];
    assign lsb_head = lsb_mem[lsb_rd_ptr];

    // NOTE: FIFO storage has no reset; emptiness is tracked by the counters alone,
    // which keeps the array out of the reset tree.
    always_ff @(posedge clk) begin
        if (alu_enq) begin
            alu_mem[alu_wr_ptr] <= '{rob_id:   bus.alu_alias,
                                     result:   bus.alu_result,
                                     jump_res: bus.alu_jump_res,
                                     jump_pc:  bus.alu_jump_pc};
        end
        if (lsb_enq) begin
            lsb_mem[lsb_wr_ptr] <= '{rob_id: bus.lsb_alias, result: bus.lsb_result};
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
        end else if (rollback_signal) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
        end else begin
            if (alu_enq) alu_wr_ptr <= alu_wr_ptr + PTR_W'(1);
            if (pop_alu) alu_rd_ptr <= alu_rd_ptr + PTR_W'(1);
            case ({alu_enq, pop_alu})
                2'b10:   alu_cnt <= alu_cnt + CNT_W'(1);
                2'b01:   alu_cnt <= alu_cnt - CNT_W'(1);
                default: alu_cnt <= alu_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsb_wr_ptr <= '0;
            lsb_rd_ptr <= '0;
            lsb_cnt    <= '0;
        end else if (rollback_signal) begin
            lsb_wr_ptr <= '0;
            lsb_rd_ptr <= '0;
            lsb_cnt    <= '0;
        end else begin
            if (lsb_enq) lsb_wr_ptr <= lsb_wr_ptr + PTR_W'(1);
            if (pop_lsb) lsb_rd_ptr <= lsb_rd_ptr + PTR_W'(1);
            case ({lsb_enq, pop_lsb})
                2'b10:   lsb_cnt <= lsb_cnt + CNT_W'(1);
                2'b01:   lsb_cnt <= lsb_cnt - CNT_W'(1);
                default: lsb_cnt <= lsb_cnt;
            endcase
        end
    end

    // NOTE: the default assignment first means no path leaves rr_next unassigned,
    // so no latch is inferred.
    always_comb begin
        rr_next = rr_last;
        if (rollback_signal) rr_next = SRC_LSB;
        else if (pop_alu)    rr_next = SRC_ALU;
        else if (pop_lsb)    rr_next = SRC_LSB;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_last <= SRC_LSB;
        else      rr_last <= rr_next;
    end

    // Data outputs only change on a pop; an idle cycle just drops cdb_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q    <= 1'b0;
            cdb_src_q      <= SRC_ALU;
            cdb_alias_q    <= '0;
            cdb_result_q   <= '0;
            cdb_jump_res_q <= 1'b0;
            cdb_jump_pc_q  <= '0;
        end else if (rollback_signal) begin
            cdb_valid_q <= 1'b0;
        end else if (rdy) begin
            if (pop_alu) begin
                cdb_valid_q    <= 1'b1;
                cdb_src_q      <= SRC_ALU;
                cdb_alias_q    <= alu_head.rob_id;
                cdb_result_q   <= alu_head.result;
                cdb_jump_res_q <= alu_head.jump_res;
                cdb_jump_pc_q  <= alu_head.jump_pc;
            end else if (pop_lsb) begin
                cdb_valid_q    <= 1'b1;
                cdb_src_q      <= SRC_LSB;
                cdb_alias_q    <= lsb_head.rob_id;
                cdb_result_q   <= lsb_head.result;
                cdb_jump_res_q <= 1'b0;
                cdb_jump_pc_q  <= '0;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_src      = cdb_src_q;
    assign bus.cdb_alias    = cdb_alias_q;
    assign bus.cdb_result   = cdb_result_q;
    assign bus.cdb_jump_res = cdb_jump_res_q;
    assign bus.cdb_jump_pc  = cdb_jump_pc_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-derived vector table, a queue-based reference model
// scoreboard, a random soak and an asynchronous-reset sequence.
module tb_cdb_arbiter;
    localparam int QDEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;
    logic rollback_signal = 1'b0;

    cdb_arbiter_if #(.ROB_ID_W(4), .DATA_W(32)) bus ();

    cdb_arbiter #(.ROB_ID_W(4), .DATA_W(32), .QDEPTH(QDEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rollback_signal (rollback_signal),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ali;
        logic [31:0] res;
        logic        jr;
        logic [31:0] jpc;
    } ent_t;

    typedef struct {
        logic        v;
        logic        src;
        logic [3:0]  ali;
        logic [31:0] res;
        logic        jr;
        logic [31:0] jpc;
    } out_t;

    typedef struct {
        logic       rst_first;
        logic       r, rb, av;
        logic [3:0] aa;
        logic       lv;
        logic [3:0] la;
        logic       e_ar, e_lr, e_v, e_src;
        logic [3:0] e_ali;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t mq_a[$];
    ent_t mq_l[$];
    logic m_rr;
    out_t m_cdb;
    out_t sb[$];
    vec_t vecs[$];
    logic got_ar, got_lr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_a.delete();
        mq_l.delete();
        m_rr  = 1'b1;
        m_cdb = '{v: 1'b0, src: 1'b0, ali: 4'd0, res: 32'd0, jr: 1'b0, jpc: 32'd0};
    endtask

    task automatic drive_idle();
        rdy = 1'b1;
        rollback_signal = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_alias = '0; bus.alu_result = '0;
        bus.alu_jump_res = 1'b0; bus.alu_jump_pc = '0;
        bus.lsb_valid = 1'b0; bus.lsb_alias = '0; bus.lsb_result = '0;
    endtask

    // Starts and ends one time unit after a rising edge.
    task automatic do_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check("rst_cdb_valid", bus.cdb_valid, 0);
        check("rst_cdb_alias", bus.cdb_alias, 0);
        check("rst_cdb_result", bus.cdb_result, 0);
        check("rst_cdb_jump_pc", bus.cdb_jump_pc, 0);
        check("rst_alu_ready", bus.alu_ready, 1);
        check("rst_lsb_ready", bus.lsb_ready, 1);
    endtask

    // One clock cycle: drive, check readies, advance the model, push the expected
    // broadcast, take the edge, pop and compare.
    task automatic step(input logic r, input logic rb,
                        input logic av, input logic [3:0] aa, input logic [31:0] ar,
                        input logic ajr, input logic [31:0] ajp,
                        input logic lv, input logic [3:0] la, input logic [31:0] lr);
        ent_t e;
        out_t exp;
        logic m_ar, m_lr;
        rdy = r;
        rollback_signal = rb;
        bus.alu_valid = av; bus.alu_alias = aa; bus.alu_result = ar;
        bus.alu_jump_res = ajr; bus.alu_jump_pc = ajp;
        bus.lsb_valid = lv; bus.lsb_alias = la; bus.lsb_result = lr;
        #1;
        m_ar = r && !rb && (mq_a.size() < QDEPTH);
        m_lr = r && !rb && (mq_l.size() < QDEPTH);
        got_ar = bus.alu_ready;
        got_lr = bus.lsb_ready;
        check("alu_ready", got_ar, m_ar);
        check("lsb_ready", got_lr, m_lr);
        if (rb) begin
            mq_a.delete();
            mq_l.delete();
            m_cdb.v = 1'b0;
            m_rr = 1'b1;
        end else if (r) begin
            if (mq_a.size() > 0 && (mq_l.size() == 0 || m_rr)) begin
                e = mq_a.pop_front();
                m_cdb = '{v: 1'b1, src: 1'b0, ali: e.ali, res: e.res, jr: e.jr, jpc: e.jpc};
                m_rr = 1'b0;
            end else if (mq_l.size() > 0) begin
                e = mq_l.pop_front();
                m_cdb = '{v: 1'b1, src: 1'b1, ali: e.ali, res: e.res, jr: 1'b0, jpc: 32'd0};
                m_rr = 1'b1;
            end else begin
                m_cdb.v = 1'b0;
            end
            if (av && m_ar) mq_a.push_back('{ali: aa, res: ar, jr: ajr, jpc: ajp});
            if (lv && m_lr) mq_l.push_back('{ali: la, res: lr, jr: 1'b0, jpc: 32'd0});
        end
        sb.push_back(m_cdb);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check("cdb_valid", bus.cdb_valid, exp.v);
        check("cdb_src", bus.cdb_src, exp.src);
        check("cdb_alias", bus.cdb_alias, exp.ali);
        check("cdb_result", bus.cdb_result, exp.res);
        check("cdb_jump_res", bus.cdb_jump_res, exp.jr);
        check("cdb_jump_pc", bus.cdb_jump_pc, exp.jpc);
    endtask

    task automatic add(input logic rf, input logic r, input logic rb, input logic av,
                       input logic [3:0] aa, input logic lv, input logic [3:0] la,
                       input logic e_ar, input logic e_lr, input logic e_v,
                       input logic e_src, input logic [3:0] e_ali);
        vec_t v;
        v.rst_first = rf; v.r = r; v.rb = rb; v.av = av; v.aa = aa; v.lv = lv; v.la = la;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_v = e_v; v.e_src = e_src; v.e_ali = e_ali;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rf r rb av aa lv la | alu_rdy lsb_rdy valid src alias (after the edge)
        // Single ALU result, one-cycle latency, one-cycle broadcast.
        add(1,1,0, 1, 3, 0, 0,   1,1, 0,0, 0);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,0, 3);
        add(0,1,0, 0, 0, 0, 0,   1,1, 0,0, 3);
        // Simultaneous offers after reset: ALU first, then alternation.
        add(1,1,0, 1, 2, 1, 5,   1,1, 0,0, 0);
        add(0,1,0, 1, 6, 1, 7,   1,1, 1,0, 2);
        add(0,1,0, 0, 0, 0, 0,   1,0, 1,1, 5);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,0, 6);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,1, 7);
        add(0,1,0, 0, 0, 0, 0,   1,1, 0,1, 7);
        // Both producers push every cycle; backpressure as each FIFO fills.
        add(0,1,0, 1, 1, 1, 8,   1,1, 0,1, 7);
        add(0,1,0, 1, 2, 1, 9,   1,1, 1,0, 1);
        add(0,1,0, 1, 3, 1,10,   1,0, 1,1, 8);
        add(0,1,0, 1, 4, 1,10,   0,1, 1,0, 2);
        add(0,1,0, 1, 4, 1,11,   1,0, 1,1, 9);
        add(0,1,0, 0, 0, 1,11,   0,1, 1,0, 3);
        add(0,1,0, 0, 0, 0, 0,   1,0, 1,1,10);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,0, 4);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,1,11);
        add(0,1,0, 0, 0, 0, 0,   1,1, 0,1,11);
        // Pause mid-broadcast for three cycles, then resume.
        add(0,1,0, 1, 5, 1,12,   1,1, 0,1,11);
        add(0,1,0, 1, 6, 1,13,   1,1, 1,0, 5);
        add(0,0,0, 1, 7, 1,14,   0,0, 1,0, 5);
        add(0,0,0, 1, 7, 1,14,   0,0, 1,0, 5);
        add(0,0,0, 1, 7, 1,14,   0,0, 1,0, 5);
        add(0,1,0, 0, 0, 0, 0,   1,0, 1,1,12);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,0, 6);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,1,13);
        add(0,1,0, 0, 0, 0, 0,   1,1, 0,1,13);
        // Rollback with both FIFOs holding entries; nothing stale afterwards.
        add(0,1,0, 1, 1, 1, 1,   1,1, 0,1,13);
        add(0,1,0, 1, 2, 1, 2,   1,1, 1,0, 1);
        add(0,1,0, 1, 3, 1, 3,   1,0, 1,1, 1);
        add(0,1,1, 1, 4, 1, 4,   0,0, 0,1, 1);
        add(0,1,0, 0, 0, 0, 0,   1,1, 0,1, 1);
        add(0,1,0, 0, 0, 0, 0,   1,1, 0,1, 1);
        add(0,1,0, 1, 9, 1, 9,   1,1, 0,1, 1);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,0, 9);
        add(0,1,0, 0, 0, 0, 0,   1,1, 1,1, 9);
        add(0,1,0, 0, 0, 0, 0,   1,1, 0,1, 9);

        drive_idle();
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            logic [31:0] idx;
            idx = 32'(i);
            if (vecs[i].rst_first) do_reset();
            step(vecs[i].r, vecs[i].rb,
                 vecs[i].av, vecs[i].aa, 32'hA000_0000 | idx, idx[0], 32'hC000_0000 | idx,
                 vecs[i].lv, vecs[i].la, 32'hB000_0000 | idx);
            check("tbl_alu_ready", got_ar, vecs[i].e_ar);
            check("tbl_lsb_ready", got_lr, vecs[i].e_lr);
            check("tbl_cdb_valid", bus.cdb_valid, vecs[i].e_v);
            check("tbl_cdb_src", bus.cdb_src, vecs[i].e_src);
            check("tbl_cdb_alias", bus.cdb_alias, vecs[i].e_ali);
        end

        // Random soak against the reference model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom(),
                 1'($urandom_range(0, 1)), $urandom(),
                 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom());
        end

        // Asynchronous reset between edges while a broadcast is valid.
        do_reset();
        step(1, 0, 1, 4'd4, 32'h44, 1'b1, 32'h400, 1, 4'd6, 32'h66);
        step(1, 0, 1, 4'd5, 32'h55, 1'b0, 32'h500, 0, 4'd0, 32'h0);
        check("pre_async_valid", bus.cdb_valid, 1);
        check("pre_async_alias", bus.cdb_alias, 4);
        #2;
        rst = 1'b0;
        #1;
        check("async_cdb_valid", bus.cdb_valid, 0);
        check("async_cdb_alias", bus.cdb_alias, 0);
        check("async_cdb_result", bus.cdb_result, 0);
        check("async_alu_ready", bus.alu_ready, 1);
        check("async_lsb_ready", bus.lsb_ready, 1);
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(1, 0, 1, 4'd7, 32'h77, 1'b0, 32'h700, 1, 4'd8, 32'h88);
        step(1, 0, 0, 4'd0, 32'h0, 1'b0, 32'h0, 0, 4'd0, 32'h0);
        check("post_rst_tie_src", bus.cdb_src, 0);
        check("post_rst_tie_alias", bus.cdb_alias, 7);
        step(1, 0, 0, 4'd0, 32'h0, 1'b0, 32'h0, 0, 4'd0, 32'h0);
        check("post_rst_second_src", bus.cdb_src, 1);
        check("post_rst_second_alias", bus.cdb_alias, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
